// File: rtl/seven_seg_pkg.sv
// Shared glyph constants and polarity helper for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_0   = 7'h3F;
    localparam logic [6:0] GLYPH_1   = 7'h06;
    localparam logic [6:0] GLYPH_2   = 7'h5B;
    localparam logic [6:0] GLYPH_3   = 7'h4F;
    localparam logic [6:0] GLYPH_4   = 7'h66;
    localparam logic [6:0] GLYPH_5   = 7'h6D;
    localparam logic [6:0] GLYPH_6   = 7'h7D;
    localparam logic [6:0] GLYPH_7   = 7'h07;
    localparam logic [6:0] GLYPH_8   = 7'h7F;
    localparam logic [6:0] GLYPH_9   = 7'h6F;
    localparam logic [6:0] GLYPH_A   = 7'h77;
    localparam logic [6:0] GLYPH_B   = 7'h7C;
    localparam logic [6:0] GLYPH_C   = 7'h39;
    localparam logic [6:0] GLYPH_D   = 7'h5E;
    localparam logic [6:0] GLYPH_E   = 7'h79;
    localparam logic [6:0] GLYPH_F   = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] apply_pol(
        input logic [6:0] seg,
        input bit         active_low
    );
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seven_seg_glyph_lut.sv
// Nibble to active-high seven-segment glyph, with a blank override.
// Hex letters render as A, b, C, d, E, F.
module seven_seg_glyph_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] glyph;

    always_comb begin
        glyph = SEG_BLANK;
        unique case (nibble_i)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
        endcase
    end

    assign seg_o = blank_i ? SEG_BLANK : glyph;

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Double-buffered, time-multiplexed N-digit seven-segment driver.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_segment_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS         = 4,
    parameter int REFRESH_DIV      = 1000,
    parameter int COMMON_ANODE     = 1,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    output logic [6:0]            o_display,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_digit_en,
    output logic                  o_frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam bit SEG_LOW = (COMMON_ANODE != 0);
    localparam bit EN_LOW  = (DIGIT_ACTIVE_LOW != 0);

    localparam logic [6:0] SEG_OFF = apply_pol(SEG_BLANK, SEG_LOW);
    localparam logic [N_DIGITS-1:0] EN_OFF = {N_DIGITS{EN_LOW}};

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pending_q, active_q;
    logic [N_DIGITS-1:0]   pending_dp_q, active_dp_q;
    logic                  pend_flag_q;
    logic [6:0]            disp_q, disp_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   en_q, en_d;
    logic                  fd_q;

    logic                  tc, last, fb;
    logic [3:0]            nibble;
    logic                  dp_sel;
    logic [N_DIGITS-1:0]   onehot;
    logic                  blank;
    logic [6:0]            seg_raw;

    always_comb begin
        tc   = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
        last = (idx_q == IDX_W'(N_DIGITS - 1));
        fb   = tc && last;
        div_cnt_d = tc ? '0 : div_cnt_q + DIV_W'(1);
        idx_d = idx_q;
        if (tc) idx_d = last ? '0 : idx_q + IDX_W'(1);
    end

    always_comb begin
        nibble = 4'h0;
        dp_sel = 1'b0;
        onehot = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble    = active_q[4*k +: 4];
                dp_sel    = active_dp_q[k];
                onehot[k] = 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; hi_zero covers digits k..N_DIGITS-1.
    logic hi_zero;
    always_comb begin
        blank   = 1'b0;
        hi_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            hi_zero = hi_zero && (active_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k) && hi_zero) blank = 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    seven_seg_glyph_lut u_lut (
        .nibble_i (nibble),
        .blank_i  (blank),
        .seg_o    (seg_raw)
    );

    always_comb begin
        disp_d = apply_pol(seg_raw, SEG_LOW);
        dp_d   = dp_sel ^ SEG_LOW;
        en_d   = onehot ^ {N_DIGITS{EN_LOW}};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            pending_dp_q <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pend_flag_q  <= 1'b0;
            disp_q       <= SEG_OFF;
            dp_q         <= SEG_LOW;
            en_q         <= EN_OFF;
            fd_q         <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            dp_q      <= dp_d;
            en_q      <= en_d;
            fd_q      <= fb;
            // A load landing on the boundary bypasses the pending buffer.
            if (fb) begin
                if (i_valid) begin
                    active_q    <= i_value;
                    active_dp_q <= i_dp;
                end else if (pend_flag_q) begin
                    active_q    <= pending_q;
                    active_dp_q <= pending_dp_q;
                end
                pend_flag_q <= 1'b0;
            end else if (i_valid) begin
                pending_q    <= i_value;
                pending_dp_q <= i_dp;
                pend_flag_q  <= 1'b1;
            end
        end
    end

    assign o_display    = disp_q;
    assign o_dp         = dp_q;
    assign o_digit_en   = en_q;
    assign o_frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench for seven_segment_scan_driver (N=4, DIV=4, CA, active-low enables).
// Honours SEVEN_SEG_LEADING_ZERO_BLANK_EN for the blanking expectations.
module tb_seven_segment_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [6:0]  disp;
    logic        odp;
    logic [3:0]  en;
    logic        fd;

    int total = 0;
    int bad   = 0;
    int n;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZERO_HI = 7'h7F;
`else
    localparam logic [6:0] ZERO_HI = 7'h40;
`endif

    seven_segment_scan_driver #(
        .N_DIGITS         (4),
        .REFRESH_DIV      (4),
        .COMMON_ANODE     (1),
        .DIGIT_ACTIVE_LOW (1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_value      (value),
        .i_dp         (dp),
        .o_display    (disp),
        .o_dp         (odp),
        .o_digit_en   (en),
        .o_frame_done (fd)
    );

    always #5 clk = ~clk;

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (fd !== 1'b1 && cnt < 64);
        chk("frame_done_seen", 32'(fd), 32'd1);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_en,
                           input logic [6:0] e_disp, input logic e_dp);
        chk({tag, "_en"}, 32'(en), 32'(e_en));
        chk({tag, "_disp"}, 32'(disp), 32'(e_disp));
        chk({tag, "_dp"}, 32'(odp), 32'(e_dp));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; value = '0; dp = '0;
        step(2);
        chk_out("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_fd", 32'(fd), 32'd0);
        rst = 1'b0;
        chk_out("release", 4'hF, 7'h7F, 1'b1);

        step(1);
        chk_out("first_d0", 4'hE, 7'h40, 1'b1);
        chk("first_fd", 32'(fd), 32'd0);
        step(3);
        chk("d0_4cyc", 32'(en), 32'hE);
        step(1);
        chk("d1_start", 32'(en), 32'hD);

        valid = 1'b1; value = 16'h12AF; dp = 4'b0100;
        step(1);
        valid = 1'b0;
        chk_out("midload_hold", 4'hD, 7'h40, 1'b1);
        wait_frame(n);
        chk("fd_latency", 32'(n), 32'd10);
        chk_out("fd_d3_old", 4'h7, 7'h40, 1'b1);

        step(1);
        chk_out("f_d0", 4'hE, 7'h0E, 1'b1);
        chk("fd_pulse_end", 32'(fd), 32'd0);
        step(4);
        chk_out("a_d1", 4'hD, 7'h08, 1'b1);
        step(4);
        chk_out("2_d2", 4'hB, 7'h24, 1'b0);
        step(4);
        chk_out("1_d3", 4'h7, 7'h79, 1'b1);

        step(2);
        valid = 1'b1; value = 16'h0005; dp = 4'b0000;
        step(1);
        valid = 1'b0;
        chk("fb_load_fd", 32'(fd), 32'd1);
        chk("fb_load_pend", 32'(dut.pend_flag_q), 32'd0);
        step(1);
        chk_out("5_d0", 4'hE, 7'h12, 1'b1);
        step(4);
        chk_out("5_d1", 4'hD, ZERO_HI, 1'b1);

        valid = 1'b1; value = 16'h1111;
        step(1);
        value = 16'h2222;
        step(1);
        valid = 1'b0;
        wait_frame(n);
        chk("two_load_wait", 32'(n), 32'd9);
        step(1);
        chk_out("2222_d0", 4'hE, 7'h24, 1'b1);
        step(12);
        chk_out("2222_d3", 4'h7, 7'h24, 1'b1);
        wait_frame(n);
        chk("frame_tail", 32'(n), 32'd3);
        wait_frame(n);
        chk("frame_period", 32'(n), 32'd16);

        valid = 1'b1; value = 16'h0000;
        step(1);
        valid = 1'b0;
        wait_frame(n);
        chk("zero_wait", 32'(n), 32'd15);
        step(1);
        chk_out("zero_d0", 4'hE, 7'h40, 1'b1);
        step(4);
        chk_out("zero_d1", 4'hD, ZERO_HI, 1'b1);

        step(4);
        chk("rst_at_d2", 32'(en), 32'hB);
        valid = 1'b1; value = 16'h4444;
        step(1);
        valid = 1'b0; rst = 1'b1;
        step(1);
        chk_out("midrst", 4'hF, 7'h7F, 1'b1);
        chk("midrst_fd", 32'(fd), 32'd0);
        chk("midrst_idx", 32'(dut.idx_q), 32'd0);
        chk("midrst_active", 32'(dut.active_q), 32'd0);
        chk("midrst_pend", 32'(dut.pend_flag_q), 32'd0);
        rst = 1'b0;
        step(1);
        chk_out("postrst_d0", 4'hE, 7'h40, 1'b1);
        wait_frame(n);
        chk("postrst_wait", 32'(n), 32'd15);
        step(1);
        chk_out("discard_d0", 4'hE, 7'h40, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
